// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if: EX/MEM pipeline register bus.
// Carries the execute-stage inputs, the stall/flush controls and the memory-stage outputs.
// Modports:
//   master - execute/hazard side: drives E inputs, StallM and FlushM; reads M outputs.
//   slave  - the register itself: reads E inputs and controls; drives M outputs.
interface ex_mem_reg_if #(
    parameter int AW = 32,
    parameter int RW = 5
);
    logic          StallM;
    logic          FlushM;
    logic          RegWriteE;
    logic          MemtoRegE;
    logic          MemWriteE;
    logic          ZeroE;
    logic [AW-1:0] ALUOutE;
    logic [AW-1:0] WriteDataE;
    logic [RW-1:0] WriteRegE;
    logic          RegWriteM;
    logic          MemtoRegM;
    logic          MemWriteM;
    logic          ZeroM;
    logic [AW-1:0] ALUOutM;
    logic [AW-1:0] WriteDataM;
    logic [RW-1:0] WriteRegM;
    logic          ValidM;
    logic          MisalignM;
    logic [15:0]   BubbleCnt;

    modport master (
        output StallM, FlushM, RegWriteE, MemtoRegE, MemWriteE, ZeroE,
               ALUOutE, WriteDataE, WriteRegE,
        input  RegWriteM, MemtoRegM, MemWriteM, ZeroM, ALUOutM, WriteDataM,
               WriteRegM, ValidM, MisalignM, BubbleCnt
    );

    modport slave (
        input  StallM, FlushM, RegWriteE, MemtoRegE, MemWriteE, ZeroE,
               ALUOutE, WriteDataE, WriteRegE,
        output RegWriteM, MemtoRegM, MemWriteM, ZeroM, ALUOutM, WriteDataM,
               WriteRegM, ValidM, MisalignM, BubbleCnt
    );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall, flush, slot validity and bubble counting.
// Ports:
//   clk - pipeline clock, rising edge
//   rst - asynchronous active-high reset
//   bus - ex_mem_reg_if.slave: E-stage inputs, StallM/FlushM, M-stage outputs
// Priority per edge: flush (load bubble) > stall (hold) > capture.
// Side-effecting controls (RegWriteM, MemtoRegM, MemWriteM) are gated by ValidM; ZeroM is not.
// Optional feature macro EXMEM_MISALIGN_EN: flags misaligned loads/stores and suppresses
// misaligned stores. When undefined MisalignM is tied 0.
module ex_mem_reg #(
    parameter int AW = 32,
    parameter int RW = 5
) (
    input logic          clk,
    input logic          rst,
    ex_mem_reg_if.slave  bus
);
    logic          valid_q, valid_d;
    logic          reg_write_q, reg_write_d;
    logic          memto_reg_q, memto_reg_d;
    logic          mem_write_q, mem_write_d;
    logic          zero_q, zero_d;
    logic [AW-1:0] alu_out_q, alu_out_d;
    logic [AW-1:0] write_data_q, write_data_d;
    logic [RW-1:0] write_reg_q, write_reg_d;
    logic [15:0]   bubble_cnt_q, bubble_cnt_d;
    logic          misalign;

    always_comb begin
        valid_d      = bus.FlushM ? 1'b0 : bus.StallM ? valid_q : 1'b1;
        reg_write_d  = bus.FlushM ? 1'b0 : bus.StallM ? reg_write_q : bus.RegWriteE;
        memto_reg_d  = bus.FlushM ? 1'b0 : bus.StallM ? memto_reg_q : bus.MemtoRegE;
        mem_write_d  = bus.FlushM ? 1'b0 : bus.StallM ? mem_write_q : bus.MemWriteE;
        zero_d       = bus.FlushM ? 1'b0 : bus.StallM ? zero_q : bus.ZeroE;
        alu_out_d    = bus.FlushM ? '0 : bus.StallM ? alu_out_q : bus.ALUOutE;
        write_data_d = bus.FlushM ? '0 : bus.StallM ? write_data_q : bus.WriteDataE;
        write_reg_d  = bus.FlushM ? '0 : bus.StallM ? write_reg_q : bus.WriteRegE;
        // Counts slots that are empty after this edge, saturating rather than wrapping.
        bubble_cnt_d = (!valid_d && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            memto_reg_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            zero_q       <= 1'b0;
            alu_out_q    <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            memto_reg_q  <= memto_reg_d;
            mem_write_q  <= mem_write_d;
            zero_q       <= zero_d;
            alu_out_q    <= alu_out_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

`ifdef EXMEM_MISALIGN_EN
    // Uses the ungated enables so the flag reflects the access the slot encodes.
    assign misalign = valid_q && (alu_out_q[1:0] != 2'b00) && (mem_write_q || memto_reg_q);
`else
    assign misalign = 1'b0;
`endif

    assign bus.RegWriteM  = reg_write_q & valid_q;
    assign bus.MemtoRegM  = memto_reg_q & valid_q;
    assign bus.MemWriteM  = mem_write_q & valid_q & ~misalign;
    assign bus.ZeroM      = zero_q;
    assign bus.ALUOutM    = alu_out_q;
    assign bus.WriteDataM = write_data_q;
    assign bus.WriteRegM  = write_reg_q;
    assign bus.ValidM     = valid_q;
    assign bus.MisalignM  = misalign;
    assign bus.BubbleCnt  = bubble_cnt_q;
endmodule
